char_line_renderer: RTL and testbench

Renders a single line of up to 16 keyboard-entered glyphs into the VGA pixel stream. Sits between the keyboard decoder and the VGA output. Stores incoming 2-bit character codes in a small line buffer, drives the character ROM's enable and 6-bit address from the live pixel counters, and serialises the returned 8-bit glyph row into RGB, with hsync/vsync realigned to match.

---
 rtl/char_pkg.sv | 16 +
 rtl/char_line_buffer.sv | 44 ++++
 rtl/char_line_renderer.sv | 116 +++++++++++
 tb/tb_char_line_renderer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// rtl/char_pkg.sv - shared geometry, widths and colours for the character line renderer
package char_pkg;
    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 16;
    localparam int CODE_W     = 2;
    localparam int ROW_W      = 4;
    localparam int ROM_ADDR_W = 6;
    localparam int LINE_CHARS = 16;

    localparam int COL_W   = $clog2(LINE_CHARS);
    localparam int COUNT_W = COL_W + 1;
    localparam int WIN_W   = GLYPH_W * LINE_CHARS;

    localparam logic [2:0] COLOR_FG_DEF = 3'b111;
    localparam logic [2:0] COLOR_BG_DEF = 3'b001;
endpackage

// File: rtl/char_line_buffer.sv
// rtl/char_line_buffer.sv - 16x2 line store with append pointer, saturation and clear
module char_line_buffer
    import char_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [CODE_W-1:0]  wr_code,
    input  logic               clear,
    input  logic [COL_W-1:0]   rd_idx,
    output logic [CODE_W-1:0]  rd_code,
    output logic [COUNT_W-1:0] count
);
    logic [CODE_W-1:0]  mem_q [LINE_CHARS];
    logic [CODE_W-1:0]  mem_d [LINE_CHARS];
    logic [COUNT_W-1:0] count_q, count_d;
    logic               full;

    assign full = (count_q == COUNT_W'(LINE_CHARS));

    // Clear only rewinds the count; stale entries stay but are never rendered.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (wr_en && !full) begin
            mem_d[count_q[COL_W-1:0]] = wr_code;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_code = mem_q[rd_idx];
    assign count   = count_q;
endmodule

// File: rtl/char_line_renderer.sv
// rtl/char_line_renderer.sv - overlays one 16-glyph text line onto the VGA pixel stream
module char_line_renderer
    import char_pkg::*;
#(
    parameter int         X_ORIGIN = 256,
    parameter int         Y_ORIGIN = 232,
    parameter logic [2:0] COLOR_FG = COLOR_FG_DEF,
    parameter logic [2:0] COLOR_BG = COLOR_BG_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [CODE_W-1:0]     key_code,
    input  logic                  key_clear,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  video_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic                  rom_en,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [GLYPH_W-1:0]    rom_data,
    output logic [2:0]            rgb,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic [COUNT_W-1:0]    char_count
);
    localparam logic [9:0] X_O = 10'(X_ORIGIN);
    localparam logic [9:0] Y_O = 10'(Y_ORIGIN);

    logic [9:0]        dx, dy;
    logic              in_win;
    logic [COL_W-1:0]  col;
    logic [2:0]        bit_idx;
    logic [ROW_W-1:0]  row;
    logic [CODE_W-1:0] cell_code;

    logic                  rom_en_q, rom_en_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [2:0]            bit_q, bit_d;
    logic                  video_on_q, video_on_d;
    logic                  in_win_q, in_win_d;
    logic                  hsync1_q, hsync1_d, vsync1_q, vsync1_d;
    logic [2:0]            rgb_q, rgb_d;
    logic                  hsync2_q, hsync2_d, vsync2_q, vsync2_d;

    char_line_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (key_valid),
        .wr_code (key_code),
        .clear   (key_clear),
        .rd_idx  (col),
        .rd_code (cell_code),
        .count   (char_count)
    );

    // Unsigned differences: anything left of/above the origin wraps large and fails the bounds.
    assign dx      = hcount - X_O;
    assign dy      = vcount - Y_O;
    assign in_win  = video_on && (dx < 10'(WIN_W)) && (dy < 10'(GLYPH_H));
    assign col     = dx[COL_W+2:3];
    assign bit_idx = dx[2:0];
    assign row     = dy[ROW_W-1:0];

    always_comb begin
        rom_en_d   = in_win && ({1'b0, col} < char_count);
        rom_addr_d = rom_en_d ? {cell_code, row} : '0;
        bit_d      = bit_idx;
        video_on_d = video_on;
        in_win_d   = in_win;
        hsync1_d   = hsync_in;
        vsync1_d   = vsync_in;
        hsync2_d   = hsync1_q;
        vsync2_d   = vsync1_q;
        rgb_d      = 3'b000;
        if (!video_on_q)
            rgb_d = 3'b000;
        else if (in_win_q && rom_en_q && rom_data[3'(GLYPH_W-1) - bit_q])
            rgb_d = COLOR_FG;
        else if (in_win_q)
            rgb_d = COLOR_BG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            bit_q      <= '0;
            video_on_q <= 1'b0;
            in_win_q   <= 1'b0;
            hsync1_q   <= 1'b1;
            vsync1_q   <= 1'b1;
            rgb_q      <= 3'b000;
            hsync2_q   <= 1'b1;
            vsync2_q   <= 1'b1;
        end else begin
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            bit_q      <= bit_d;
            video_on_q <= video_on_d;
            in_win_q   <= in_win_d;
            hsync1_q   <= hsync1_d;
            vsync1_q   <= vsync1_d;
            rgb_q      <= rgb_d;
            hsync2_q   <= hsync2_d;
            vsync2_q   <= vsync2_d;
        end
    end

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign rgb       = rgb_q;
    assign hsync_out = hsync2_q;
    assign vsync_out = vsync2_q;
endmodule

// File: tb/tb_char_line_renderer.sv
// tb/tb_char_line_renderer.sv - directed self-checking bench for char_line_renderer
module tb_char_line_renderer;
    localparam logic [9:0] XO = 10'd256;
    localparam logic [9:0] YO = 10'd232;
    localparam logic [2:0] FG = 3'b111;
    localparam logic [2:0] BG = 3'b001;

    logic       clk = 1'b0;
    logic       reset, key_valid, key_clear, video_on, hsync_in, vsync_in;
    logic [1:0] key_code;
    logic [9:0] hcount, vcount;
    logic       rom_en;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic [2:0] rgb;
    logic       hsync_out, vsync_out;
    logic [4:0] char_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Glyph ROM model: code 0 row 0 is 00011000, other rows carry their address with bit 7 set.
    function automatic logic [7:0] glyph(input logic [5:0] a);
        if (a == 6'd0) return 8'b0001_1000;
        return {2'b10, a};
    endfunction

    assign rom_data = rom_en ? glyph(rom_addr) : 8'h00;

    char_line_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_clear  (key_clear),
        .hcount     (hcount),
        .vcount     (vcount),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .char_count (char_count)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [1:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic clear_line();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic von);
        hcount   = h;
        vcount   = v;
        video_on = von;
        tick();
    endtask

    logic hs_pat [10];
    logic vs_pat [10];

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_clear = 1'b0; key_code = 2'd0;
        hcount = 10'd0; vcount = 10'd0; video_on = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        tick();
        tick();
        check("rst_rgb", 16'(rgb), 16'd0);
        check("rst_hsync", 16'(hsync_out), 16'd1);
        check("rst_vsync", 16'(vsync_out), 16'd1);
        check("rst_rom_en", 16'(rom_en), 16'd0);
        check("rst_rom_addr", 16'(rom_addr), 16'd0);
        check("rst_count", 16'(char_count), 16'd0);
        reset = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        tick();
        tick();

        // Keys 1,2,3 then sample cell 1 row 4
        key(2'd1); key(2'd2); key(2'd3);
        check("count3", 16'(char_count), 16'd3);
        pix(XO + 10'd8, YO + 10'd4, 1'b1);
        check("c1_rom_en", 16'(rom_en), 16'd1);
        check("c1_rom_addr", 16'(rom_addr), 16'(6'b10_0100));
        tick();
        check("c1_rgb_fg", 16'(rgb), 16'(FG));

        // Fresh line with key 0: glyph row 0 = 00011000
        clear_line();
        key(2'd0);
        check("count1", 16'(char_count), 16'd1);
        pix(XO + 10'd3, YO, 1'b1);
        check("g0_rom_en", 16'(rom_en), 16'd1);
        check("g0_rom_addr", 16'(rom_addr), 16'd0);
        tick();
        check("g0_bit3_fg", 16'(rgb), 16'(FG));
        pix(XO, YO, 1'b1);
        tick();
        check("g0_bit0_bg", 16'(rgb), 16'(BG));

        // Fill to 16, then a dropped 17th key
        clear_line();
        for (int i = 0; i < 16; i++) key(2'(i % 4));
        check("count16", 16'(char_count), 16'd16);
        key(2'd3);
        check("count_sat", 16'(char_count), 16'd16);
        pix(XO + 10'd120, YO + 10'd5, 1'b1);
        check("c15_rom_en", 16'(rom_en), 16'd1);
        check("c15_rom_addr", 16'(rom_addr), 16'(6'b11_0101));
        pix(XO, YO + 10'd5, 1'b1);
        check("c0_rom_en", 16'(rom_en), 16'd1);
        check("c0_kept", 16'(rom_addr), 16'(6'b00_0101));

        // Clear beats a simultaneous key
        key_clear = 1'b1; key_valid = 1'b1; key_code = 2'd1;
        tick();
        key_clear = 1'b0; key_valid = 1'b0;
        check("clr_wins", 16'(char_count), 16'd0);
        pix(XO + 10'd8, YO + 10'd4, 1'b1);
        check("empty_rom_en", 16'(rom_en), 16'd0);
        check("empty_rom_addr", 16'(rom_addr), 16'd0);
        tick();
        check("empty_bg", 16'(rgb), 16'(BG));
        pix(XO + 10'd128, YO, 1'b1);
        tick();
        check("right_out", 16'(rgb), 16'd0);
        pix(XO - 10'd1, YO, 1'b1);
        tick();
        check("left_out", 16'(rgb), 16'd0);
        pix(XO, YO + 10'd16, 1'b1);
        tick();
        check("below_out", 16'(rgb), 16'd0);
        pix(XO + 10'd127, YO + 10'd15, 1'b1);
        tick();
        check("corner_bg", 16'(rgb), 16'(BG));

        // Blanking inside the window
        key(2'd0);
        pix(XO + 10'd3, YO, 1'b0);
        check("blank_rom_en", 16'(rom_en), 16'd0);
        tick();
        check("blank_rgb", 16'(rgb), 16'd0);

        // Sync pulses come out two cycles later with identical width
        for (int k = 0; k < 10; k++) begin
            hs_pat[k] = !(k >= 2 && k < 5);
            vs_pat[k] = !(k == 3);
        end
        for (int k = 0; k < 10; k++) begin
            hsync_in = hs_pat[k];
            vsync_in = vs_pat[k];
            tick();
            if (k >= 1) begin
                check($sformatf("hsync_k%0d", k), 16'(hsync_out), 16'(hs_pat[k-1]));
                check($sformatf("vsync_k%0d", k), 16'(vsync_out), 16'(vs_pat[k-1]));
            end
        end

        // Reset mid-line while rendering a lit pixel
        pix(XO + 10'd3, YO, 1'b1);
        hsync_in = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_rgb", 16'(rgb), 16'd0);
        check("mid_rst_rom_en", 16'(rom_en), 16'd0);
        check("mid_rst_count", 16'(char_count), 16'd0);
        check("mid_rst_hsync", 16'(hsync_out), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
